// File: rtl/mpu_sequencer.sv
// Element-serial sequencer for the 5x5 signed 8-bit matrix unit: ADD, SUB, TRANSPOSE at LANES elements/cycle.
// Optional build macro MPU_SATURATE_EN clamps overflowing ADD/SUB elements instead of wrapping.
module mpu_sequencer #(
  parameter int LANES  = 1,
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [DIM*DIM*ELEM_W-1:0]     matrix_a,
  input  logic [DIM*DIM*ELEM_W-1:0]     matrix_b,
  output logic [DIM*DIM*ELEM_W-1:0]     result,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic                          busy,
  output logic                          overflow,
  output logic                          cmd_error
);

  localparam int NELEM = DIM * DIM;
  localparam int MW    = NELEM * ELEM_W;
  localparam int CW    = $clog2(NELEM + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_TRANS = 2'b10, OP_ILLEGAL = 2'b11} op_t;

  state_t              state, state_next;
  op_t                 op_q;
  logic [MW-1:0]       a_q, b_q;
  logic [CW-1:0]       count, count_next;
  logic [ELEM_W-1:0]   elem_res [NELEM];
  logic [NELEM-1:0]    elem_ovf;
  logic [NELEM-1:0]    lane_mask;
  logic                accept;

  assign accept       = (state == IDLE) && cmd_valid;
  assign cmd_ready    = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state == RUN) || (state == DONE);
  assign count_next   = count + CW'(LANES);

  // Every element is computed in parallel; lane_mask picks the ones written this cycle.
  for (genvar k = 0; k < NELEM; k++) begin : g_elem
    localparam int SRC = (k % DIM) * DIM + (k / DIM);
    logic [ELEM_W-1:0] a_e, b_e, arith;
    logic [ELEM_W:0]   wide;
    logic              ovf;

    assign a_e  = a_q[k*ELEM_W +: ELEM_W];
    assign b_e  = b_q[k*ELEM_W +: ELEM_W];
    assign wide = (op_q == OP_SUB) ? ({a_e[ELEM_W-1], a_e} - {b_e[ELEM_W-1], b_e})
                                   : ({a_e[ELEM_W-1], a_e} + {b_e[ELEM_W-1], b_e});
    assign ovf  = wide[ELEM_W] ^ wide[ELEM_W-1];
`ifdef MPU_SATURATE_EN
    assign arith = !ovf ? wide[ELEM_W-1:0]
                 : (wide[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}});
`else
    assign arith = wide[ELEM_W-1:0];
`endif
    assign elem_res[k] = (op_q == OP_TRANS) ? a_q[SRC*ELEM_W +: ELEM_W] : arith;
    assign elem_ovf[k] = (op_q != OP_TRANS) && ovf;
  end

  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < NELEM; k++)
      lane_mask[k] = (k >= int'(count)) && (k < int'(count) + LANES);
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    state_next = state;
    unique case (state)
      IDLE: if (cmd_valid) state_next = (op_t'(cmd_op) == OP_ILLEGAL) ? DONE : RUN;
      RUN:  if (count_next >= CW'(NELEM)) state_next = DONE;
      DONE: if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      cmd_error <= 1'b0;
    end else if (accept) begin
      count     <= '0;
      overflow  <= 1'b0;
      cmd_error <= (op_t'(cmd_op) == OP_ILLEGAL);
    end else if (state == RUN) begin
      for (int k = 0; k < NELEM; k++)
        if (lane_mask[k]) result[k*ELEM_W +: ELEM_W] <= elem_res[k];
      if (|(lane_mask & elem_ovf)) overflow <= 1'b1;
      count <= count_next;
    end
  end

  // NOTE: operand registers are pure data captured on acceptance, so they carry no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      a_q  <= matrix_a;
      b_q  <= matrix_b;
      op_q <= op_t'(cmd_op);
    end
  end

endmodule
